// File: rtl/tx_csum_arb_pkg.sv
// Shared types for the tx_checksum request arbiter: FSM states and the
// per-packet checksum command bundle.
package tx_csum_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA
  } state_t;

  typedef struct packed {
    logic        enable;
    logic [7:0]  start;
    logic [7:0]  offset;
    logic [15:0] init;
  } csum_cmd_struct;

  localparam int CMD_W = 33;

endpackage

// File: rtl/tx_csum_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping from NUM_SRC-1 back to 0.
module rr_pick #(
  parameter int NUM_SRC = 4,
  parameter int SRC_W   = 2
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [SRC_W-1:0]   ptr,
  output logic               any,
  output logic [SRC_W-1:0]   idx
);

  logic [SRC_W:0] pos;
  logic           found;

  always_comb begin
    any   = |req;
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      // One extra bit lets ptr+k exceed NUM_SRC-1 before the single wrap.
      pos = {1'b0, ptr} + (SRC_W + 1)'(k);
      if (pos >= (SRC_W + 1)'(NUM_SRC)) begin
        pos = pos - (SRC_W + 1)'(NUM_SRC);
      end
      if (!found && req[pos[SRC_W-1:0]]) begin
        found = 1'b1;
        idx   = pos[SRC_W-1:0];
      end
    end
  end

endmodule

// File: rtl/tx_csum_arbiter.sv
// Packet-granular round-robin arbiter sharing one tx_checksum among
// NUM_SRC requesters: grant, pass the command through, then the packet.
module tx_csum_arbiter
  import tx_csum_arb_pkg::*;
#(
  parameter int NUM_SRC    = 4,
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int SRC_W      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_SRC-1:0]            src_cmd_csum_enable,
  input  logic [8*NUM_SRC-1:0]          src_cmd_csum_start,
  input  logic [8*NUM_SRC-1:0]          src_cmd_csum_offset,
  input  logic [16*NUM_SRC-1:0]         src_cmd_csum_init,
  input  logic [NUM_SRC-1:0]            src_cmd_valid,
  output logic [NUM_SRC-1:0]            src_cmd_ready,
  input  logic [DATA_WIDTH*NUM_SRC-1:0] src_axis_tdata,
  input  logic [KEEP_WIDTH*NUM_SRC-1:0] src_axis_tkeep,
  input  logic [NUM_SRC-1:0]            src_axis_tvalid,
  output logic [NUM_SRC-1:0]            src_axis_tready,
  input  logic [NUM_SRC-1:0]            src_axis_tlast,
  output logic                          m_axis_cmd_csum_enable,
  output logic [7:0]                    m_axis_cmd_csum_start,
  output logic [7:0]                    m_axis_cmd_csum_offset,
  output logic [15:0]                   m_axis_cmd_csum_init,
  output logic                          m_axis_cmd_valid,
  input  logic                          m_axis_cmd_ready,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]         m_axis_tkeep,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic                          busy,
  output logic [SRC_W-1:0]              cur_src
);

  state_t           state_q, state_d;
  logic [SRC_W-1:0] grant_q, grant_d;
  logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [SRC_W-1:0] grant_next;
  logic             pick_any;
  logic [SRC_W-1:0] pick_idx;
  csum_cmd_struct   cmd_sel;

  logic [CMD_W-1:0]      cmd_a   [NUM_SRC];
  logic [DATA_WIDTH-1:0] tdata_a [NUM_SRC];
  logic [KEEP_WIDTH-1:0] tkeep_a [NUM_SRC];

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_unpack
    assign cmd_a[g]   = {src_cmd_csum_enable[g], src_cmd_csum_start[8*g +: 8],
                         src_cmd_csum_offset[8*g +: 8], src_cmd_csum_init[16*g +: 16]};
    assign tdata_a[g] = src_axis_tdata[DATA_WIDTH*g +: DATA_WIDTH];
    assign tkeep_a[g] = src_axis_tkeep[KEEP_WIDTH*g +: KEEP_WIDTH];
  end

  rr_pick #(
    .NUM_SRC (NUM_SRC),
    .SRC_W   (SRC_W)
  ) u_rr_pick (
    .req (src_cmd_valid),
    .ptr (rr_ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign grant_next = (grant_q == SRC_W'(NUM_SRC - 1)) ? '0 : grant_q + 1'b1;
  assign cmd_sel    = csum_cmd_struct'(cmd_a[grant_q]);
  assign busy       = (state_q != IDLE);
  assign cur_src    = grant_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  always_comb begin
    state_d                = state_q;
    grant_d                = grant_q;
    rr_ptr_d               = rr_ptr_q;
    src_cmd_ready          = '0;
    src_axis_tready        = '0;
    m_axis_cmd_valid       = 1'b0;
    m_axis_cmd_csum_enable = 1'b0;
    m_axis_cmd_csum_start  = '0;
    m_axis_cmd_csum_offset = '0;
    m_axis_cmd_csum_init   = '0;
    m_axis_tdata           = '0;
    m_axis_tkeep           = '0;
    m_axis_tvalid          = 1'b0;
    m_axis_tlast           = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d = pick_idx;
          state_d = CMD;
        end
      end
      CMD: begin
        m_axis_cmd_valid        = src_cmd_valid[grant_q];
        m_axis_cmd_csum_enable  = cmd_sel.enable;
        m_axis_cmd_csum_start   = cmd_sel.start;
        m_axis_cmd_csum_offset  = cmd_sel.offset;
        m_axis_cmd_csum_init    = cmd_sel.init;
        src_cmd_ready[grant_q]  = m_axis_cmd_ready;
        if (m_axis_cmd_valid && m_axis_cmd_ready) begin
          state_d = DATA;
        end
      end
      DATA: begin
        m_axis_tdata             = tdata_a[grant_q];
        m_axis_tkeep             = tkeep_a[grant_q];
        m_axis_tvalid            = src_axis_tvalid[grant_q];
        m_axis_tlast             = src_axis_tlast[grant_q];
        src_axis_tready[grant_q] = m_axis_tready;
        // Advancing the pointer here makes the just-served source lowest priority.
        if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
          rr_ptr_d = grant_next;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_tx_csum_arbiter.sv
// Scoreboard bench for tx_csum_arbiter: queued packets per source, a
// packet-level round-robin reference model, and per-cycle output checks.
module tb_tx_csum_arbiter;

  localparam int NS = 4;
  localparam int DW = 64;
  localparam int KW = 8;

  typedef struct packed {
    logic        en;
    logic [7:0]  st;
    logic [7:0]  off;
    logic [15:0] init;
  } cmd_t;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
  } beat_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NS-1:0]   src_cmd_csum_enable;
  logic [8*NS-1:0] src_cmd_csum_start;
  logic [8*NS-1:0] src_cmd_csum_offset;
  logic [16*NS-1:0] src_cmd_csum_init;
  logic [NS-1:0]   src_cmd_valid;
  logic [NS-1:0]   src_cmd_ready;
  logic [DW*NS-1:0] src_axis_tdata;
  logic [KW*NS-1:0] src_axis_tkeep;
  logic [NS-1:0]   src_axis_tvalid;
  logic [NS-1:0]   src_axis_tready;
  logic [NS-1:0]   src_axis_tlast;
  logic            m_axis_cmd_csum_enable;
  logic [7:0]      m_axis_cmd_csum_start;
  logic [7:0]      m_axis_cmd_csum_offset;
  logic [15:0]     m_axis_cmd_csum_init;
  logic            m_axis_cmd_valid;
  logic            m_axis_cmd_ready;
  logic [DW-1:0]   m_axis_tdata;
  logic [KW-1:0]   m_axis_tkeep;
  logic            m_axis_tvalid;
  logic            m_axis_tready;
  logic            m_axis_tlast;
  logic            busy;
  logic [1:0]      cur_src;

  tx_csum_arbiter #(
    .NUM_SRC    (NS),
    .DATA_WIDTH (DW)
  ) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .src_cmd_csum_enable    (src_cmd_csum_enable),
    .src_cmd_csum_start     (src_cmd_csum_start),
    .src_cmd_csum_offset    (src_cmd_csum_offset),
    .src_cmd_csum_init      (src_cmd_csum_init),
    .src_cmd_valid          (src_cmd_valid),
    .src_cmd_ready          (src_cmd_ready),
    .src_axis_tdata         (src_axis_tdata),
    .src_axis_tkeep         (src_axis_tkeep),
    .src_axis_tvalid        (src_axis_tvalid),
    .src_axis_tready        (src_axis_tready),
    .src_axis_tlast         (src_axis_tlast),
    .m_axis_cmd_csum_enable (m_axis_cmd_csum_enable),
    .m_axis_cmd_csum_start  (m_axis_cmd_csum_start),
    .m_axis_cmd_csum_offset (m_axis_cmd_csum_offset),
    .m_axis_cmd_csum_init   (m_axis_cmd_csum_init),
    .m_axis_cmd_valid       (m_axis_cmd_valid),
    .m_axis_cmd_ready       (m_axis_cmd_ready),
    .m_axis_tdata           (m_axis_tdata),
    .m_axis_tkeep           (m_axis_tkeep),
    .m_axis_tvalid          (m_axis_tvalid),
    .m_axis_tready          (m_axis_tready),
    .m_axis_tlast           (m_axis_tlast),
    .busy                   (busy),
    .cur_src                (cur_src)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Stimulus-side queues (what each source still has to send) and the
  // scoreboard copies (what the arbiter output must still show).
  cmd_t  drv_cmd  [NS][$];
  beat_t drv_beat [NS][$];
  cmd_t  exp_cmd  [NS][$];
  beat_t exp_beat [NS][$];

  int            mode = 0;
  int            cyc = 0;
  int            issued = 0;
  logic [NS-1:0] hs_c = '0;
  logic [NS-1:0] hs_d = '0;

  // Reference model: packet-level phase, served source and rotating priority.
  int ph = 0;
  int gsrc = 0;
  int ptr = 0;
  int beat_n = 0;
  int pkt_done = 0;
  int sel;
  int grant_log[$];
  cmd_t  mc;
  beat_t mb;

  always @(negedge clk) begin
    if (!rst_n) begin
      ph = 0; gsrc = 0; ptr = 0; beat_n = 0;
      for (int i = 0; i < NS; i++) begin
        exp_cmd[i].delete();
        exp_beat[i].delete();
      end
    end else begin
      chk("busy", 64'(busy), 64'(ph != 0));
      if (ph != 0) chk("cur_src", 64'(cur_src), 64'(gsrc));
      case (ph)
        0: begin
          chk("idle_cmd_valid", 64'(m_axis_cmd_valid), 64'(0));
          chk("idle_tvalid", 64'(m_axis_tvalid), 64'(0));
          chk("idle_src_cmd_ready", 64'(src_cmd_ready), 64'(0));
          chk("idle_src_tready", 64'(src_axis_tready), 64'(0));
          sel = -1;
          for (int k = 0; k < NS; k++)
            if (sel < 0 && src_cmd_valid[(ptr + k) % NS]) sel = (ptr + k) % NS;
          if (sel >= 0) begin
            gsrc = sel;
            grant_log.push_back(sel);
            ph = 1;
            beat_n = 0;
          end
        end
        1: begin
          chk("cmd_valid", 64'(m_axis_cmd_valid), 64'(src_cmd_valid[gsrc]));
          chk("cmd_src_ready", 64'(src_cmd_ready), 64'(4'(m_axis_cmd_ready) << gsrc));
          chk("cmd_src_tready", 64'(src_axis_tready), 64'(0));
          chk("cmd_tvalid", 64'(m_axis_tvalid), 64'(0));
          if (m_axis_cmd_valid) begin
            chk("cmd_avail", 64'(exp_cmd[gsrc].size() != 0), 64'(1));
            if (exp_cmd[gsrc].size() != 0) begin
              mc = exp_cmd[gsrc][0];
              chk("cmd_enable", 64'(m_axis_cmd_csum_enable), 64'(mc.en));
              chk("cmd_start", 64'(m_axis_cmd_csum_start), 64'(mc.st));
              chk("cmd_offset", 64'(m_axis_cmd_csum_offset), 64'(mc.off));
              chk("cmd_init", 64'(m_axis_cmd_csum_init), 64'(mc.init));
              if (m_axis_cmd_ready) begin
                void'(exp_cmd[gsrc].pop_front());
                ph = 2;
              end
            end
          end
        end
        default: begin
          chk("data_tvalid", 64'(m_axis_tvalid), 64'(src_axis_tvalid[gsrc]));
          chk("data_src_tready", 64'(src_axis_tready), 64'(4'(m_axis_tready) << gsrc));
          chk("data_src_cmd_ready", 64'(src_cmd_ready), 64'(0));
          chk("data_cmd_valid", 64'(m_axis_cmd_valid), 64'(0));
          if (m_axis_tvalid) begin
            chk("beat_avail", 64'(exp_beat[gsrc].size() != 0), 64'(1));
            if (exp_beat[gsrc].size() != 0) begin
              mb = exp_beat[gsrc][0];
              chk("tdata", m_axis_tdata, mb.d);
              chk("tkeep", 64'(m_axis_tkeep), 64'(mb.k));
              chk("tlast", 64'(m_axis_tlast), 64'(mb.l));
              if (m_axis_tready) begin
                void'(exp_beat[gsrc].pop_front());
                beat_n++;
                if (mb.l) begin
                  ptr = (gsrc + 1) % NS;
                  ph = 0;
                  pkt_done++;
                end
              end
            end
          end
        end
      endcase
    end
  end

  function automatic void drive();
    cmd_t  c;
    beat_t b;
    logic  hold;
    for (int i = 0; i < NS; i++) begin
      if (drv_cmd[i].size() != 0) begin
        c = drv_cmd[i][0];
        src_cmd_valid[i] = 1'b1;
      end else begin
        c = '0;
        src_cmd_valid[i] = 1'b0;
      end
      src_cmd_csum_enable[i]        = c.en;
      src_cmd_csum_start[8*i +: 8]  = c.st;
      src_cmd_csum_offset[8*i +: 8] = c.off;
      src_cmd_csum_init[16*i +: 16] = c.init;
      hold = src_axis_tvalid[i] && !hs_d[i];
      if (drv_beat[i].size() != 0) begin
        b = drv_beat[i][0];
        src_axis_tvalid[i] = hold || (mode != 2) || ($urandom_range(0, 2) != 0);
      end else begin
        b = '0;
        src_axis_tvalid[i] = 1'b0;
      end
      src_axis_tdata[DW*i +: DW] = b.d;
      src_axis_tkeep[KW*i +: KW] = b.k;
      src_axis_tlast[i]          = b.l;
    end
    case (mode)
      0: begin m_axis_cmd_ready = 1'b1; m_axis_tready = 1'b1; end
      1: begin m_axis_cmd_ready = (cyc % 4 == 3); m_axis_tready = (cyc % 8 >= 5); end
      default: begin
        m_axis_cmd_ready = ($urandom_range(0, 3) != 0);
        m_axis_tready    = ($urandom_range(0, 3) != 0);
      end
    endcase
  endfunction

  task automatic step();
    @(negedge clk);
    hs_c = src_cmd_valid & src_cmd_ready;
    hs_d = src_axis_tvalid & src_axis_tready;
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < NS; i++) begin
      if (hs_c[i]) void'(drv_cmd[i].pop_front());
      if (hs_d[i]) void'(drv_beat[i].pop_front());
    end
    drive();
  endtask

  task automatic issue(input int s, input cmd_t c, input int n);
    beat_t b;
    drv_cmd[s].push_back(c);
    exp_cmd[s].push_back(c);
    for (int j = 0; j < n; j++) begin
      b.d = {$urandom, $urandom};
      b.k = 8'($urandom);
      b.l = (j == n - 1);
      drv_beat[s].push_back(b);
      exp_beat[s].push_back(b);
    end
    issued++;
  endtask

  function automatic cmd_t rand_cmd();
    cmd_t c;
    c.en   = 1'($urandom);
    c.st   = 8'($urandom);
    c.off  = 8'($urandom);
    c.init = 16'($urandom);
    return c;
  endfunction

  function automatic int pending();
    int p = (ph != 0) ? 1 : 0;
    for (int i = 0; i < NS; i++)
      if (drv_cmd[i].size() != 0 || drv_beat[i].size() != 0 || exp_beat[i].size() != 0) p = 1;
    return p;
  endfunction

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (pending() != 0 && n < budget) begin
      step();
      n++;
    end
    chk({"drain_", name}, 64'(pending()), 64'(0));
  endtask

  task automatic clear_sources();
    for (int i = 0; i < NS; i++) begin
      drv_cmd[i].delete();
      drv_beat[i].delete();
    end
    hs_c = '0;
    hs_d = '0;
    src_axis_tvalid = '0;
    drive();
  endtask

  initial begin
    int exp_order[5];
    int n;
    cmd_t c;
    rst_n = 1'b0;
    src_cmd_valid = '0;
    src_axis_tvalid = '0;
    drive();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_cur_src", 64'(cur_src), 64'(0));
    chk("rst_cmd_valid", 64'(m_axis_cmd_valid), 64'(0));
    chk("rst_tvalid", 64'(m_axis_tvalid), 64'(0));
    chk("rst_src_cmd_ready", 64'(src_cmd_ready), 64'(0));
    chk("rst_src_tready", 64'(src_axis_tready), 64'(0));

    // All four requesting from reset release, single-beat packets.
    grant_log.delete();
    rst_n = 1'b1;
    issue(0, rand_cmd(), 1);
    issue(1, rand_cmd(), 1);
    issue(2, rand_cmd(), 1);
    issue(3, rand_cmd(), 1);
    issue(0, rand_cmd(), 1);
    drive();
    drain("order", 200);
    exp_order = '{0, 1, 2, 3, 0};
    chk("order_len", 64'(grant_log.size()), 64'(5));
    for (int i = 0; i < 5 && i < grant_log.size(); i++)
      chk("order_grant", 64'(grant_log[i]), 64'(exp_order[i]));

    // Fixed command fields on src0, three beats.
    c.en = 1'b1; c.st = 8'd34; c.off = 8'd50; c.init = 16'h1234;
    issue(0, c, 3);
    drive();
    drain("src0", 100);

    // Patterned backpressure on both command and data channels.
    mode = 1;
    issue(1, rand_cmd(), 6);
    drive();
    drain("bp", 300);
    mode = 0;

    // src2 data presented long before its command is granted.
    issue(0, rand_cmd(), 8);
    drive();
    step();
    c = rand_cmd();
    c.en = 1'b0;
    issue(2, c, 3);
    drive();
    drain("early", 200);

    // Randomised traffic with random backpressure and valid gaps.
    mode = 2;
    n = 0;
    for (int t = 0; t < 4000 && n < 150; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        issue($urandom_range(0, NS - 1), rand_cmd(), $urandom_range(1, 8));
        n++;
      end
      step();
    end
    drain("random", 8000);
    mode = 0;
    chk("pkt_count", 64'(pkt_done), 64'(issued));

    // Asynchronous reset on beat 2 of a src1 packet; pointer parked at 3 first.
    issue(2, rand_cmd(), 1);
    drive();
    drain("park", 50);
    issue(1, rand_cmd(), 4);
    drive();
    n = 0;
    while (!(ph == 2 && gsrc == 1 && beat_n == 1) && n < 100) begin
      step();
      n++;
    end
    chk("reach_beat2", 64'(ph == 2 && gsrc == 1 && beat_n == 1), 64'(1));
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'(0));
    chk("arst_cur_src", 64'(cur_src), 64'(0));
    chk("arst_tvalid", 64'(m_axis_tvalid), 64'(0));
    chk("arst_tdata", m_axis_tdata, 64'(0));
    chk("arst_tlast", 64'(m_axis_tlast), 64'(0));
    chk("arst_src_tready", 64'(src_axis_tready), 64'(0));
    chk("arst_src_cmd_ready", 64'(src_cmd_ready), 64'(0));
    chk("arst_cmd_valid", 64'(m_axis_cmd_valid), 64'(0));
    clear_sources();
    repeat (2) step();
    grant_log.delete();
    rst_n = 1'b1;
    issue(3, rand_cmd(), 2);
    issue(1, rand_cmd(), 2);
    drive();
    drain("post_rst", 100);
    chk("post_rst_len", 64'(grant_log.size()), 64'(2));
    if (grant_log.size() == 2) begin
      chk("post_rst_first", 64'(grant_log[0]), 64'(1));
      chk("post_rst_second", 64'(grant_log[1]), 64'(3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
